endian_bus_bridge: RTL and testbench

ENDIAN_BUS_BRIDGE -- requirements
Module: endian_bus_bridge

---
 rtl/endian_bridge_pkg.sv | 14 +
 rtl/endian_swapper.sv | 21 ++
 rtl/endian_bus_bridge.sv | 173 +++++++++++++++++
 tb/tb_endian_bus_bridge.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/endian_bridge_pkg.sv
// Shared types and lane-width constants for the endian bus bridge.
package endian_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int BYTE_BITS    = 8;
  // Write lanes carry a byte plus its enable bit so one swap reverses both.
  localparam int WR_LANE_BITS = BYTE_BITS + 1;

endpackage

// File: rtl/endian_swapper.sv
// Reverses the order of N_BYTES lanes of LANE_BITS each when i_swap is set.
module endian_swapper
  import endian_bridge_pkg::*;
#(
  parameter int N_BYTES   = 4,
  parameter int LANE_BITS = BYTE_BITS
) (
  input  logic                           i_swap,
  input  logic [N_BYTES*LANE_BITS-1:0]   i_data,
  output logic [N_BYTES*LANE_BITS-1:0]   o_data
);

  logic [N_BYTES*LANE_BITS-1:0] w_rev;

  for (genvar i = 0; i < N_BYTES; i++) begin : g_lane
    assign w_rev[i*LANE_BITS +: LANE_BITS] = i_data[(N_BYTES-1-i)*LANE_BITS +: LANE_BITS];
  end

  assign o_data = i_swap ? w_rev : i_data;

endmodule

// File: rtl/endian_bus_bridge.sv
// Single-outstanding bus bridge with optional byte reversal and downstream timeout.
//   state    | meaning
//   ST_IDLE  | waiting for a single upstream read or write request
//   ST_ISSUE | downstream strobe held from holding regs until done or timeout
//   ST_RESP  | one-cycle completion, up_busy low, up_rdata valid
module endian_bus_bridge
  import endian_bridge_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int TIMEOUT = 255,
  localparam int N_BITS = BYTE_BITS * N_BYTES
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               swap_en,
  input  logic               up_ren,
  input  logic               up_wen,
  input  logic [31:0]        up_addr,
  input  logic [N_BITS-1:0]  up_wdata,
  input  logic [N_BYTES-1:0] up_byte_en,
  output logic               up_busy,
  output logic [N_BITS-1:0]  up_rdata,
  output logic               dn_ren,
  output logic               dn_wen,
  output logic [31:0]        dn_addr,
  output logic [N_BITS-1:0]  dn_wdata,
  output logic [N_BYTES-1:0] dn_byte_en,
  input  logic               dn_busy,
  input  logic [N_BITS-1:0]  dn_rdata,
  output logic               err
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  logic [31:0]        r_addr;
  logic [N_BITS-1:0]  r_wdata;
  logic [N_BYTES-1:0] r_be;
  logic               r_wr;
  logic               r_swap;
  logic [N_BITS-1:0]  r_rdata;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_err;

  logic w_req_one;
  logic w_req_both;
  logic w_timeout;

  logic [N_BYTES*WR_LANE_BITS-1:0] w_wr_lanes;
  logic [N_BYTES*WR_LANE_BITS-1:0] w_wr_lanes_sw;
  logic [N_BITS-1:0]               w_wdata_cap;
  logic [N_BYTES-1:0]              w_be_cap;
  logic [N_BITS-1:0]               w_rdata_sw;

  assign w_req_one  = up_ren ^ up_wen;
  assign w_req_both = up_ren & up_wen;
  assign w_timeout  = (TIMEOUT != 0) && dn_busy && (r_wait == WAIT_LAST);

  for (genvar i = 0; i < N_BYTES; i++) begin : g_pack
    assign w_wr_lanes[i*WR_LANE_BITS +: WR_LANE_BITS] =
      {up_byte_en[i], up_wdata[i*BYTE_BITS +: BYTE_BITS]};
    assign w_wdata_cap[i*BYTE_BITS +: BYTE_BITS] = w_wr_lanes_sw[i*WR_LANE_BITS +: BYTE_BITS];
    assign w_be_cap[i] = w_wr_lanes_sw[i*WR_LANE_BITS + BYTE_BITS];
  end

  // Write path uses the live swap_en since it is sampled at capture time.
  endian_swapper #(
    .N_BYTES   (N_BYTES),
    .LANE_BITS (WR_LANE_BITS)
  ) u_wr_swap (
    .i_swap (swap_en),
    .i_data (w_wr_lanes),
    .o_data (w_wr_lanes_sw)
  );

  endian_swapper #(
    .N_BYTES   (N_BYTES),
    .LANE_BITS (BYTE_BITS)
  ) u_rd_swap (
    .i_swap (r_swap),
    .i_data (dn_rdata),
    .o_data (w_rdata_sw)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    up_busy = 1'b0;
    dn_ren  = 1'b0;
    dn_wen  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        up_busy = w_req_one;
        if (w_req_one) begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        up_busy = 1'b1;
        dn_ren  = ~r_wr;
        dn_wen  = r_wr;
        if (!dn_busy || w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_swap  <= 1'b0;
      r_rdata <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_one) begin
            r_addr  <= up_addr;
            r_wdata <= w_wdata_cap;
            r_be    <= w_be_cap;
            r_wr    <= up_wen;
            r_swap  <= swap_en;
            r_wait  <= '0;
          end else if (w_req_both) begin
            r_err <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!dn_busy) begin
            if (!r_wr) begin
              r_rdata <= w_rdata_sw;
            end
          end else if (w_timeout) begin
            r_rdata <= '1;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dn_addr    = r_addr;
  assign dn_wdata   = r_wdata;
  assign dn_byte_en = r_be;
  assign up_rdata   = r_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_endian_bus_bridge.sv
// Directed bench for endian_bus_bridge with an up_rdata scoreboard queue.
module tb_endian_bus_bridge;

  localparam int NB = 4;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        swap_en;
  logic        up_ren, up_wen;
  logic [31:0] up_addr;
  logic [31:0] up_wdata;
  logic [3:0]  up_byte_en;
  logic        up_busy;
  logic [31:0] up_rdata;
  logic        dn_ren, dn_wen;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic [3:0]  dn_byte_en;
  logic        dn_busy;
  logic [31:0] dn_rdata;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_rdata;
  logic        exp_err;

  always #5 CLK = ~CLK;

  endian_bus_bridge #(.N_BYTES(NB), .TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .swap_en    (swap_en),
    .up_ren     (up_ren),
    .up_wen     (up_wen),
    .up_addr    (up_addr),
    .up_wdata   (up_wdata),
    .up_byte_en (up_byte_en),
    .up_busy    (up_busy),
    .up_rdata   (up_rdata),
    .dn_ren     (dn_ren),
    .dn_wen     (dn_wen),
    .dn_addr    (dn_addr),
    .dn_wdata   (dn_wdata),
    .dn_byte_en (dn_byte_en),
    .dn_busy    (dn_busy),
    .dn_rdata   (dn_rdata),
    .err        (err)
  );

  function automatic logic [31:0] brev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // busy_n: ISSUE cycles with dn_busy high before it drops; >= TO forces a timeout.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input bit swap, input logic [31:0] rd,
                     input int busy_n, input bit toggle_swap, input string tag);
    bit          to;
    int          issue_cycles;
    logic [31:0] exp_dw;
    logic [3:0]  exp_be;
    logic [31:0] got;
    to           = (busy_n >= TO);
    issue_cycles = to ? TO : busy_n + 1;
    exp_dw       = swap ? brev(wdata) : wdata;
    exp_be       = swap ? bitrev4(be) : be;
    if (to)       model_rdata = 32'hFFFF_FFFF;
    else if (!wr) model_rdata = swap ? brev(rd) : rd;
    if (to) exp_err = 1'b1;
    sb_q.push_back(model_rdata);

    @(posedge CLK); #1;
    up_ren = !wr; up_wen = wr; up_addr = addr; up_wdata = wdata;
    up_byte_en = be; swap_en = swap; dn_busy = 1'b1; dn_rdata = rd;
    #1;
    chk({tag, "_c0_busy"}, up_busy, 1);
    chk({tag, "_c0_strobe"}, {dn_ren, dn_wen}, 0);

    for (int c = 1; c <= issue_cycles; c++) begin
      @(posedge CLK); #1;
      if (toggle_swap) swap_en = ~swap_en;
      dn_busy = (c <= busy_n);
      #1;
      chk({tag, "_iss_busy"}, up_busy, 1);
      chk({tag, "_iss_strobe"}, {dn_ren, dn_wen}, {30'd0, !wr, wr});
      chk({tag, "_iss_addr"}, dn_addr, addr);
      chk({tag, "_iss_wdata"}, dn_wdata, exp_dw);
      chk({tag, "_iss_be"}, dn_byte_en, exp_be);
    end

    @(posedge CLK); #1;
    up_ren = 1'b0; up_wen = 1'b0; dn_busy = 1'b1;
    #1;
    chk({tag, "_resp_busy"}, up_busy, 0);
    chk({tag, "_resp_strobe"}, {dn_ren, dn_wen}, 0);
    chk({tag, "_resp_err"}, err, exp_err);
    got = sb_q.pop_front();
    chk({tag, "_resp_rdata"}, up_rdata, got);

    @(posedge CLK); #2;
    chk({tag, "_idle_busy"}, up_busy, 0);
    chk({tag, "_idle_rdata_hold"}, up_rdata, model_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; swap_en = 1'b0; up_ren = 1'b0; up_wen = 1'b0;
    up_addr = '0; up_wdata = '0; up_byte_en = '0; dn_busy = 1'b1; dn_rdata = '0;
    model_rdata = '0; exp_err = 1'b0;

    repeat (2) @(posedge CLK);
    #2;
    chk("rst_busy", up_busy, 0);
    chk("rst_strobe", {dn_ren, dn_wen}, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", up_rdata, 0);
    chk("rst_addr", dn_addr, 0);
    @(posedge CLK); #1 nRST = 1'b1;

    txn(1'b1, 32'h100, 32'h1122_3344, 4'b0011, 1'b1, 32'h0, 0, 1'b0, "wr_swap");
    txn(1'b0, 32'h104, 32'h0, 4'b1111, 1'b1, 32'hAABB_CCDD, 3, 1'b0, "rd_swap");
    txn(1'b0, 32'h108, 32'h0, 4'b1111, 1'b0, 32'hAABB_CCDD, 2, 1'b1, "rd_noswap_tog");
    txn(1'b1, 32'h10C, 32'hCAFE_F00D, 4'b0110, 1'b0, 32'h1234_5678, 1, 1'b0, "wr_noswap");

    // Both strobes at once: rejected in IDLE, err becomes sticky.
    @(posedge CLK); #1;
    up_ren = 1'b1; up_wen = 1'b1;
    #1;
    chk("coll_busy", up_busy, 0);
    chk("coll_strobe", {dn_ren, dn_wen}, 0);
    @(posedge CLK); #2;
    chk("coll_err", err, 1);
    chk("coll_strobe2", {dn_ren, dn_wen}, 0);
    up_ren = 1'b0; up_wen = 1'b0;

    // Reset asserted while a read sits in ISSUE.
    @(posedge CLK); #1;
    up_ren = 1'b1; up_addr = 32'h200; swap_en = 1'b0; dn_busy = 1'b1;
    #1;
    chk("rstmid_c0_busy", up_busy, 1);
    @(posedge CLK); #2;
    chk("rstmid_issue_ren", dn_ren, 1);
    #1;
    nRST = 1'b0; up_ren = 1'b0;
    #1;
    chk("rstmid_strobe", {dn_ren, dn_wen}, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_busy", up_busy, 0);
    chk("rstmid_rdata", up_rdata, 0);
    chk("rstmid_addr", dn_addr, 0);
    model_rdata = '0; exp_err = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;

    txn(1'b0, 32'h300, 32'h0, 4'b1111, 1'b0, 32'h0BAD_BEEF, 0, 1'b0, "rd_after_rst");
    txn(1'b0, 32'h304, 32'h0, 4'b1111, 1'b1, 32'h5555_AAAA, 4, 1'b0, "rd_timeout");
    txn(1'b1, 32'h308, 32'h8765_4321, 4'b1000, 1'b1, 32'h0, 0, 1'b0, "wr_after_to");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
